// File: rtl/branch_cond_unit_pkg.sv
// rtl/branch_cond_unit_pkg.sv - shared types and constants for the branch condition unit
//
// Purpose: condition-code enum, FSM state enum, flag bit positions and the
//          flag-legality helper used by branch_cond_unit and branch_cond_eval.
// Ports:   none (package).
package CPU_package;

  localparam int CPU_DATA_WIDTH = 16;

  // Flag register bit positions as produced by the ALU logic unit.
  localparam int FLAG_EQ = 2;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LT = 0;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_EQ     = 3'd1,
    COND_NE     = 3'd2,
    COND_GT     = 3'd3,
    COND_LT     = 3'd4,
    COND_GE     = 3'd5,
    COND_LE     = 3'd6,
    COND_NEVER  = 3'd7
  } enum_branch_cond_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } enum_br_state_t;

  // A compare result is at most one of EQ/GT/LT; all-zero is the "no compare yet" value.
  function automatic logic flags_legal(input logic [2:0] f);
    return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
  endfunction

endpackage

// File: rtl/branch_cond_unit_eval.sv
// rtl/branch_cond_unit_eval.sv - combinational branch condition evaluator
//
// Purpose: decide taken/not-taken from a condition code and the flag register.
// Ports:   cond  [2:0] in  - enum_branch_cond_t code
//          flags [2:0] in  - {EQ, GT, LT}
//          taken       out - condition satisfied
module branch_cond_eval
  import CPU_package::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (enum_branch_cond_t'(cond))
      COND_ALWAYS: taken = 1'b1;
      COND_EQ:     taken = flags[FLAG_EQ];
      COND_NE:     taken = !flags[FLAG_EQ];
      COND_GT:     taken = flags[FLAG_GT];
      COND_LT:     taken = flags[FLAG_LT];
      COND_GE:     taken = flags[FLAG_GT] | flags[FLAG_EQ];
      COND_LE:     taken = flags[FLAG_LT] | flags[FLAG_EQ];
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// rtl/branch_cond_unit.sv - branch resolution unit with flag register and redirect handshake
//
// Purpose: latch ALU compare flags, accept branch requests, resolve them one
//          cycle later and present the next PC to fetch until it is accepted.
// Ports:   clk, rst                        - clock, async active-high reset
//          flag_in[2:0], flag_wr           - flag register write
//          br_valid, br_ready, br_cond,
//          br_target, pc_in                - branch request handshake
//          redirect_valid, redirect_ready,
//          redirect_pc, taken              - resolved next-PC handshake
//          flags_q, flag_err               - flag register, illegal-write pulse
//          br_cnt, taken_cnt               - saturating statistics counters
module branch_cond_unit
  import CPU_package::*;
#(
  parameter int DATA_WIDTH = CPU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            flag_in,
  input  logic                  flag_wr,
  input  logic                  br_valid,
  output logic                  br_ready,
  input  logic [2:0]            br_cond,
  input  logic [DATA_WIDTH-1:0] br_target,
  input  logic [DATA_WIDTH-1:0] pc_in,
  output logic                  redirect_valid,
  input  logic                  redirect_ready,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  taken,
  output logic [2:0]            flags_q,
  output logic                  flag_err,
  output logic [DATA_WIDTH-1:0] br_cnt,
  output logic [DATA_WIDTH-1:0] taken_cnt
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] CNT_MAX = {DATA_WIDTH{1'b1}};

  enum_br_state_t        state;
  logic [2:0]            cond_q;
  logic [DATA_WIDTH-1:0] target_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic                  eval_taken;
  logic                  flag_ok;

  assign flag_ok = flags_legal(flag_in);

  // EVAL reads flags_q, so a write landing on the acceptance edge is seen,
  // while a write during EVAL lands on the same edge the decision is latched.
  branch_cond_eval u_eval (
    .cond  (cond_q),
    .flags (flags_q),
    .taken (eval_taken)
  );

  assign br_ready       = (state == ST_IDLE);
  assign redirect_valid = (state == ST_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      flags_q     <= 3'b000;
      flag_err    <= 1'b0;
      cond_q      <= 3'b000;
      target_q    <= '0;
      pc_q        <= '0;
      taken       <= 1'b0;
      redirect_pc <= '0;
      br_cnt      <= '0;
      taken_cnt   <= '0;
    end else begin
      flag_err <= flag_wr && !flag_ok;
      if (flag_wr && flag_ok) begin
        flags_q <= flag_in;
      end

      case (state)
        ST_IDLE: begin
          if (br_valid) begin
            cond_q   <= br_cond;
            target_q <= br_target;
            pc_q     <= pc_in;
            state    <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          taken       <= eval_taken;
          redirect_pc <= eval_taken ? target_q : pc_q + PC_STEP;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (redirect_ready) begin
            state <= ST_IDLE;
            if (br_cnt != CNT_MAX) begin
              br_cnt <= br_cnt + PC_STEP;
            end
            if (taken && (taken_cnt != CNT_MAX)) begin
              taken_cnt <= taken_cnt + PC_STEP;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// tb/tb_branch_cond_unit.sv - directed self-checking bench for branch_cond_unit
module tb_branch_cond_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  flag_in = 3'b000;
  logic        flag_wr = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_ready;
  logic [2:0]  br_cond = 3'd0;
  logic [15:0] br_target = 16'h0;
  logic [15:0] pc_in = 16'h0;
  logic        redirect_valid;
  logic        redirect_ready = 1'b1;
  logic [15:0] redirect_pc;
  logic        taken;
  logic [2:0]  flags_q;
  logic        flag_err;
  logic [15:0] br_cnt;
  logic [15:0] taken_cnt;

  // 4-bit instance so counter saturation is reachable in a few dozen cycles
  logic        s_br_valid = 1'b0;
  logic [2:0]  s_br_cond = 3'd0;
  logic        s_br_ready, s_redirect_valid, s_taken, s_flag_err;
  logic [3:0]  s_redirect_pc, s_br_cnt, s_taken_cnt;
  logic [2:0]  s_flags_q;

  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_tk = 0;

  always #5 clk = ~clk;

  branch_cond_unit #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .flag_in(flag_in), .flag_wr(flag_wr),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
    .br_target(br_target), .pc_in(pc_in), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .taken(taken),
    .flags_q(flags_q), .flag_err(flag_err), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  branch_cond_unit #(.DATA_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .flag_in(3'b000), .flag_wr(1'b0),
    .br_valid(s_br_valid), .br_ready(s_br_ready), .br_cond(s_br_cond),
    .br_target(4'hA), .pc_in(4'h3), .redirect_valid(s_redirect_valid),
    .redirect_ready(1'b1), .redirect_pc(s_redirect_pc), .taken(s_taken),
    .flags_q(s_flags_q), .flag_err(s_flag_err), .br_cnt(s_br_cnt), .taken_cnt(s_taken_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_flags(input logic [2:0] f);
    flag_wr = 1'b1;
    flag_in = f;
    tick();
    flag_wr = 1'b0;
  endtask

  // Drives one request in an IDLE cycle; lat counts cycles from the accept cycle to redirect_valid.
  task automatic issue(input logic [2:0] c, input logic [15:0] tgt, input logic [15:0] pc, output int lat);
    br_valid  = 1'b1;
    br_cond   = c;
    br_target = tgt;
    pc_in     = pc;
    tick();
    br_valid = 1'b0;
    lat = 1;
    while (!redirect_valid && lat < 8) begin
      tick();
      lat++;
    end
  endtask

  task automatic complete(input logic was_taken);
    int n;
    redirect_ready = 1'b1;
    n = 0;
    while (redirect_valid && n < 8) begin
      tick();
      n++;
    end
    exp_br++;
    if (was_taken) exp_tk++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_br_ready got %b want 1", br_ready); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", redirect_valid); end
    checks++; if (taken !== 1'b0 || redirect_pc !== 16'h0) begin errors++; $display("FAIL reset_redirect got taken=%b pc=%h want 0/0000", taken, redirect_pc); end
    checks++; if (flags_q !== 3'b000 || flag_err !== 1'b0) begin errors++; $display("FAIL reset_flags got %b err=%b want 000/0", flags_q, flag_err); end
    checks++; if (br_cnt !== 16'h0 || taken_cnt !== 16'h0) begin errors++; $display("FAIL reset_counters got %h/%h want 0000/0000", br_cnt, taken_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_flags();
    int lat;
    logic [2:0] nt_conds [5] = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
    issue(3'd2, 16'h0300, 16'h0020, lat);
    checks++; if (taken !== 1'b1 || redirect_pc !== 16'h0300) begin errors++; $display("FAIL ne_zero_flags got taken=%b pc=%h want 1/0300", taken, redirect_pc); end
    complete(1'b1);
    foreach (nt_conds[i]) begin
      issue(nt_conds[i], 16'h0300, 16'h0020, lat);
      checks++; if (taken !== 1'b0 || redirect_pc !== 16'h0021) begin errors++; $display("FAIL zero_flags_cond%0d got taken=%b pc=%h want 0/0021", nt_conds[i], taken, redirect_pc); end
      complete(1'b0);
    end
  endtask

  task automatic test_eq_taken();
    int lat;
    write_flags(3'b100);
    checks++; if (flags_q !== 3'b100) begin errors++; $display("FAIL flag_load got %b want 100", flags_q); end
    issue(3'd1, 16'h0200, 16'h0010, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL eq_latency got %0d want 2", lat); end
    checks++; if (taken !== 1'b1 || redirect_pc !== 16'h0200) begin errors++; $display("FAIL eq_taken got taken=%b pc=%h want 1/0200", taken, redirect_pc); end
    complete(1'b1);
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL back_to_back_ready got %b want 1", br_ready); end
    checks++; if (br_cnt !== 16'(exp_br) || taken_cnt !== 16'(exp_tk)) begin errors++; $display("FAIL eq_counters got %0d/%0d want %0d/%0d", br_cnt, taken_cnt, exp_br, exp_tk); end
  endtask

  task automatic test_le_wrap();
    int lat;
    write_flags(3'b010);
    issue(3'd6, 16'h1234, 16'hFFFF, lat);
    checks++; if (taken !== 1'b0 || redirect_pc !== 16'h0000) begin errors++; $display("FAIL le_wrap got taken=%b pc=%h want 0/0000", taken, redirect_pc); end
    complete(1'b0);
    issue(3'd5, 16'h1234, 16'h00FF, lat);
    checks++; if (taken !== 1'b1 || redirect_pc !== 16'h1234) begin errors++; $display("FAIL ge_gt got taken=%b pc=%h want 1/1234", taken, redirect_pc); end
    complete(1'b1);
  endtask

  task automatic test_flag_err();
    write_flags(3'b110);
    checks++; if (flag_err !== 1'b1) begin errors++; $display("FAIL flag_err_pulse got %b want 1", flag_err); end
    checks++; if (flags_q !== 3'b010) begin errors++; $display("FAIL flag_err_hold got %b want 010", flags_q); end
    tick();
    checks++; if (flag_err !== 1'b0) begin errors++; $display("FAIL flag_err_width got %b want 0", flag_err); end
  endtask

  task automatic test_stall();
    int lat;
    redirect_ready = 1'b0;
    issue(3'd3, 16'h4444, 16'h1000, lat);
    for (int i = 0; i < 5; i++) begin
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 16'h4444 || taken !== 1'b1 || br_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d got v=%b pc=%h t=%b rdy=%b want 1/4444/1/0", i, redirect_valid, redirect_pc, taken, br_ready);
      end
      br_valid  = (i == 1);
      br_cond   = 3'd7;
      pc_in     = 16'h7777;
      br_target = 16'h8888;
      tick();
    end
    br_valid = 1'b0;
    complete(1'b1);
    checks++; if (br_ready !== 1'b1 || br_cnt !== 16'(exp_br)) begin errors++; $display("FAIL stall_release got rdy=%b cnt=%0d want 1/%0d", br_ready, br_cnt, exp_br); end
    tick();
    tick();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL stall_pulse_ignored got %b want 0", redirect_valid); end
  endtask

  task automatic test_flag_timing();
    br_valid  = 1'b1;
    br_cond   = 3'd4;
    br_target = 16'h0AB0;
    pc_in     = 16'h0100;
    flag_wr   = 1'b1;
    flag_in   = 3'b001;
    redirect_ready = 1'b0;
    tick();
    br_valid = 1'b0;
    flag_in  = 3'b100;
    tick();
    flag_wr = 1'b0;
    checks++; if (redirect_valid !== 1'b1 || taken !== 1'b1 || redirect_pc !== 16'h0AB0) begin
      errors++; $display("FAIL accept_flag_lt got v=%b t=%b pc=%h want 1/1/0ab0", redirect_valid, taken, redirect_pc);
    end
    tick();
    checks++; if (flags_q !== 3'b100 || taken !== 1'b1) begin errors++; $display("FAIL eval_flag_ignored got flags=%b t=%b want 100/1", flags_q, taken); end
    complete(1'b1);
    checks++; if (br_cnt !== 16'(exp_br) || taken_cnt !== 16'(exp_tk)) begin errors++; $display("FAIL timing_counters got %0d/%0d want %0d/%0d", br_cnt, taken_cnt, exp_br, exp_tk); end
  endtask

  task automatic test_reset_in_resp();
    int lat;
    redirect_ready = 1'b0;
    issue(3'd0, 16'h5555, 16'h0010, lat);
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL resp_reached got %b want 1", redirect_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (redirect_valid !== 1'b0 || taken !== 1'b0 || redirect_pc !== 16'h0 || br_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset got v=%b t=%b pc=%h rdy=%b want 0/0/0000/1", redirect_valid, taken, redirect_pc, br_ready);
    end
    checks++; if (br_cnt !== 16'h0 || taken_cnt !== 16'h0 || flags_q !== 3'b000) begin errors++; $display("FAIL async_reset_state got %h/%h/%b want 0/0/000", br_cnt, taken_cnt, flags_q); end
    rst = 1'b0;
    exp_br = 0;
    exp_tk = 0;
    redirect_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (redirect_valid !== 1'b0 || br_cnt !== 16'h0) begin errors++; $display("FAIL abandoned got v=%b cnt=%h want 0/0000", redirect_valid, br_cnt); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) begin
      s_br_cond  = 3'd0;
      s_br_valid = 1'b1;
      tick();
      s_br_valid = 1'b0;
      tick();
      tick();
      if (i == 14) begin
        checks++; if (s_taken_cnt !== 4'hF || s_br_cnt !== 4'hF) begin errors++; $display("FAIL sat_reach got %h/%h want f/f", s_br_cnt, s_taken_cnt); end
      end
    end
    checks++; if (s_taken_cnt !== 4'hF || s_br_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got %h/%h want f/f", s_br_cnt, s_taken_cnt); end
    s_br_cond  = 3'd7;
    s_br_valid = 1'b1;
    tick();
    s_br_valid = 1'b0;
    tick();
    checks++; if (s_redirect_valid !== 1'b1 || s_taken !== 1'b0 || s_redirect_pc !== 4'h4) begin errors++; $display("FAIL small_never got v=%b t=%b pc=%h want 1/0/4", s_redirect_valid, s_taken, s_redirect_pc); end
    tick();
    checks++; if (s_taken_cnt !== 4'hF || s_br_cnt !== 4'hF) begin errors++; $display("FAIL sat_never got %h/%h want f/f", s_br_cnt, s_taken_cnt); end
  endtask

  initial begin
    test_reset();
    test_zero_flags();
    test_eq_taken();
    test_le_wrap();
    test_flag_err();
    test_stall();
    test_flag_timing();
    test_reset_in_resp();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 16 (CPU_package), SHALL set the width of PC, target and counters.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 flag_in  in  3  compare flags from the ALU logic unit: bit2 EQ, bit1 GT, bit0 LT.
REQ-005 flag_wr  in  1  latch flag_in into the flag register this cycle.
REQ-006 br_valid  in  1  branch request valid.
REQ-007 br_ready  out  1  unit can accept a request.
REQ-008 br_cond  in  3  enum_branch_cond_t condition code.
REQ-009 br_target  in  DATA_WIDTH  jump target.
REQ-010 pc_in  in  DATA_WIDTH  PC of the branch instruction.
REQ-011 redirect_valid  out  1  resolved next-PC valid.
REQ-012 redirect_ready  in  1  fetch accepts the redirect.
REQ-013 redirect_pc  out  DATA_WIDTH  next PC.
REQ-014 taken  out  1  branch taken, qualified by redirect_valid.
REQ-015 flags_q  out  3  current flag register.
REQ-016 flag_err  out  1  one-cycle pulse on illegal flag write.
REQ-017 br_cnt, taken_cnt  out  DATA_WIDTH each  resolved-branch and taken-branch counters.

Function
REQ-018 Conditions SHALL be: ALWAYS=0 (taken), EQ=1, NE=2 (!EQ), GT=3, LT=4, GE=5 (GT|EQ), LE=6 (LT|EQ), NEVER=7 (not taken).
REQ-019 flag_wr with flag_in one-hot or 3'b000 SHALL load flags_q at the next edge.
REQ-020 flag_wr with any other flag_in SHALL leave flags_q unchanged and pulse flag_err high for exactly one cycle.
REQ-021 FSM states SHALL be IDLE, EVAL and RESP.
REQ-022 br_ready SHALL be 1 only in IDLE.
REQ-023 In IDLE, br_valid=1 SHALL capture br_cond, br_target and pc_in and move to EVAL.
REQ-024 EVAL SHALL last one cycle. It SHALL compute taken from the captured condition and flags_q, register the decision and move to RESP.
REQ-025 A flag_wr in the acceptance cycle SHALL be visible to EVAL.
REQ-026 A flag_wr during EVAL or RESP SHALL NOT alter the registered decision.
REQ-027 Latency: request accepted at edge N SHALL give redirect_valid=1 from edge N+2.
REQ-028 In RESP, redirect_valid SHALL be 1 and redirect_pc and taken SHALL be held stable until redirect_ready=1.
REQ-029 In RESP with redirect_ready=1, the handshake SHALL complete and the FSM SHALL return to IDLE; back-to-back requests SHALL therefore have a 3-cycle minimum spacing.
REQ-030 redirect_pc SHALL be br_target when taken, else pc_in+1 modulo 2^DATA_WIDTH (16'hFFFF wraps to 16'h0000).
REQ-031 With flags_q=000, EQ/GT/LT/GE/LE SHALL be not taken and NE SHALL be taken.
REQ-032 On each completed redirect handshake, br_cnt SHALL increment, and taken_cnt SHALL increment when taken=1.
REQ-033 Both counters SHALL saturate at all-ones.

Reset
REQ-034 rst SHALL asynchronously force IDLE, flags_q=0, flag_err=0, redirect_valid=0, taken=0, redirect_pc=0, br_cnt=0 and taken_cnt=0, with br_ready=1.
REQ-035 rst in EVAL or RESP SHALL abandon the pending branch with no redirect and no counter update.

Structure
REQ-036 CPU_package SHALL hold enum_branch_cond_t, the FSM state enum, and FLAG_EQ=2, FLAG_GT=1, FLAG_LT=0.
REQ-037 Condition evaluation SHALL be one combinational sub-module, branch_cond_eval (cond, flags -> taken); sequencing, registers and counters SHALL stay in branch_cond_unit.

Verification
REQ-038 flag_wr with flag_in=100, then br_cond=EQ, pc_in=0x0010, br_target=0x0200, redirect_ready=1 -> redirect_valid exactly 2 cycles after accept, taken=1, redirect_pc=0x0200, br_cnt=1, taken_cnt=1.
REQ-039 flags 010, br_cond=LE, pc_in=0xFFFF -> taken=0, redirect_pc=0x0000.
REQ-040 flag_in=110 with flag_wr -> flag_err pulse of 1 cycle, flags_q unchanged; br_cond=NE on reset flags -> taken=1.
REQ-041 redirect_ready held 0 for 5 cycles -> redirect_valid, redirect_pc and taken stable; br_ready=0; a br_valid pulse in that window is ignored.
REQ-042 flag_wr=001 in the acceptance cycle of br_cond=LT -> taken=1; flag_wr=100 during EVAL -> decision unchanged.
REQ-043 rst asserted during RESP -> outputs at reset values immediately, no counter change; taken_cnt preloaded to 0xFFFF stays 0xFFFF after a further taken branch.
